// File: rtl/queue_source_arbiter_pkg.sv
// Purpose: frame-token encoding shared by the camera path, the pattern generator and the arbiter.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package queue_source_arbiter_pkg;

  localparam int TOKEN_W = 17;

  typedef logic [TOKEN_W-1:0] token_t;

  localparam token_t TOKEN_SOF = 17'h10000;
  localparam token_t TOKEN_ROW = 17'h10001;
  localparam token_t TOKEN_EOF = 17'h1FFFF;

  // Pixels carry {1'b0, rgb565}; everything with bit16 set is a framing marker.
  function automatic logic is_pixel(input token_t tok);
    return ~tok[TOKEN_W-1];
  endfunction

  function automatic logic is_marker(input token_t tok);
    return tok[TOKEN_W-1];
  endfunction

endpackage

// File: rtl/queue_source_arbiter_if.sv
// Purpose: one token write port (data, write strobe, full back-pressure).
// Latency: none (wires only).
// Backpressure: full is driven by the consumer and honoured by the producer.
interface queue_source_arbiter_if;
  import queue_source_arbiter_pkg::*;

  token_t data;
  logic   wr_en;
  logic   full;

  modport master (output data, output wr_en, input full);
  modport slave  (input data, input wr_en, output full);

endinterface

// File: rtl/queue_source_arbiter_token_mux2.sv
// Purpose: selects the active source's token/strobe and fans queue_full back to it.
// Latency: combinational.
// Backpressure: only the active source sees queue_full; hold_off releases both sources.
module token_mux2
  import queue_source_arbiter_pkg::*;
(
  input  logic   sel,
  input  logic   hold_off,
  input  token_t src0_data,
  input  logic   src0_wr_en,
  input  token_t src1_data,
  input  logic   src1_wr_en,
  input  logic   queue_full,
  output token_t act_data,
  output logic   act_wr_en,
  output logic   inact_wr_en,
  output logic   src0_full,
  output logic   src1_full
);

  assign act_data    = sel ? src1_data  : src0_data;
  assign act_wr_en   = sel ? src1_wr_en : src0_wr_en;
  assign inact_wr_en = sel ? src0_wr_en : src1_wr_en;

  // The non-active source free-runs so it never stalls while waiting for ownership.
  assign src0_full = queue_full & ~sel & ~hold_off;
  assign src1_full = queue_full &  sel & ~hold_off;

endmodule

// File: rtl/queue_source_arbiter.sv
// Purpose: shares one frame-token queue between two sources, switching only on frame boundaries.
// Latency: 1 cycle from accepted source token to queue write.
// Backpressure: queue_full passes to the active source only; non-active tokens are dropped and counted.
module queue_source_arbiter
  import queue_source_arbiter_pkg::*;
#(
  parameter logic DEFAULT_SRC    = 1'b0,
  parameter int   TIMEOUT_CYCLES = 4096,
  parameter int   CNT_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    src_sel,
  queue_source_arbiter_if.slave   src0,
  queue_source_arbiter_if.slave   src1,
  queue_source_arbiter_if.master  queue,
  output logic                    queue_wr_clk,
  output logic                    active_src,
  output logic [CNT_WIDTH-1:0]    frame_count,
  output logic [CNT_WIDTH-1:0]    drop_count,
  output logic                    proto_err
);

  typedef enum logic [1:0] {
    ST_SEEK  = 2'd0,
    ST_FRAME = 2'd1,
    ST_GAP   = 2'd2,
    ST_ABORT = 2'd3
  } arb_state_t;

  // Counter holds 0..TIMEOUT_CYCLES-1; the abort fires on the cycle it would reach TIMEOUT_CYCLES.
  localparam int              TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic            TO_EN   = (TIMEOUT_CYCLES != 0);

  arb_state_t        state, state_nxt;
  logic              active_nxt;
  token_t            q_data, q_data_nxt;
  logic              q_wr, q_wr_nxt;
  logic              frame_inc;
  logic              proto_set;
  logic              seen_row, seen_row_nxt;
  logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
  logic              act_dropped;

  token_t            act_data;
  logic              act_wr_en;
  logic              inact_wr_en;
  logic              accepted;
  logic              switch_req;

  logic [1:0]        drop_inc;
  logic [CNT_WIDTH:0] drop_sum;

  token_mux2 u_mux (
    .sel         (active_src),
    .hold_off    (state == ST_ABORT),
    .src0_data   (src0.data),
    .src0_wr_en  (src0.wr_en),
    .src1_data   (src1.data),
    .src1_wr_en  (src1.wr_en),
    .queue_full  (queue.full),
    .act_data    (act_data),
    .act_wr_en   (act_wr_en),
    .inact_wr_en (inact_wr_en),
    .src0_full   (src0.full),
    .src1_full   (src1.full)
  );

  assign queue_wr_clk = clk;
  assign queue.data   = q_data;
  assign queue.wr_en  = q_wr;
  assign accepted     = act_wr_en & ~queue.full;
  assign switch_req   = (src_sel != active_src);

  // Drop counter saturates; up to two tokens (one per source) can be dropped in a cycle.
  assign drop_inc = {1'b0, inact_wr_en} + {1'b0, act_dropped};
  assign drop_sum = {1'b0, drop_count} + {{(CNT_WIDTH-1){1'b0}}, drop_inc};

  // Next-state, ownership, queue write and protocol checks.
  always_comb begin
    state_nxt    = state;
    active_nxt   = active_src;
    q_wr_nxt     = 1'b0;
    q_data_nxt   = q_data;
    frame_inc    = 1'b0;
    proto_set    = 1'b0;
    seen_row_nxt = seen_row;
    to_cnt_nxt   = '0;
    act_dropped  = 1'b0;
    case (state)
      ST_SEEK: begin
        if (accepted && act_data == TOKEN_SOF) begin
          q_wr_nxt     = 1'b1;
          q_data_nxt   = act_data;
          seen_row_nxt = 1'b0;
          state_nxt    = ST_FRAME;
        end else begin
          // Ownership tracks the request freely until a frame is picked up.
          active_nxt  = src_sel;
          act_dropped = accepted;
        end
      end
      ST_FRAME: begin
        if (accepted) begin
          q_wr_nxt   = 1'b1;
          q_data_nxt = act_data;
          if (act_data == TOKEN_SOF) proto_set = 1'b1;
          if (is_pixel(act_data) && !seen_row) proto_set = 1'b1;
          if (act_data == TOKEN_ROW) seen_row_nxt = 1'b1;
        end
        // A real EOF beats a timeout landing on the same cycle.
        if (accepted && act_data == TOKEN_EOF) begin
          frame_inc = 1'b1;
          state_nxt = ST_GAP;
        end else if (switch_req && TO_EN) begin
          if (to_cnt == TO_LAST) state_nxt = ST_ABORT;
          else                   to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      ST_GAP: begin
        if (switch_req) begin
          active_nxt  = src_sel;
          act_dropped = accepted;
          state_nxt   = ST_SEEK;
        end else if (accepted) begin
          if (act_data == TOKEN_SOF) begin
            q_wr_nxt     = 1'b1;
            q_data_nxt   = act_data;
            seen_row_nxt = 1'b0;
            state_nxt    = ST_FRAME;
          end else begin
            act_dropped = 1'b1;
            proto_set   = 1'b1;
          end
        end
      end
      ST_ABORT: begin
        // Source is released here, so every valid word it presents is discarded.
        act_dropped = act_wr_en;
        if (!queue.full) begin
          q_wr_nxt   = 1'b1;
          q_data_nxt = TOKEN_EOF;
          frame_inc  = 1'b1;
          active_nxt = src_sel;
          state_nxt  = ST_SEEK;
        end
      end
      default: state_nxt = ST_SEEK;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_SEEK;
    else          state <= state_nxt;
  end

  // Registered queue port, ownership, counters and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_src  <= DEFAULT_SRC;
      q_wr        <= 1'b0;
      q_data      <= '0;
      frame_count <= '0;
      drop_count  <= '0;
      proto_err   <= 1'b0;
      seen_row    <= 1'b0;
      to_cnt      <= '0;
    end else begin
      active_src  <= active_nxt;
      q_wr        <= q_wr_nxt;
      q_data      <= q_data_nxt;
      frame_count <= frame_count + {{(CNT_WIDTH-1){1'b0}}, frame_inc};
      drop_count  <= drop_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : drop_sum[CNT_WIDTH-1:0];
      proto_err   <= proto_err | proto_set;
      seen_row    <= seen_row_nxt;
      to_cnt      <= to_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_queue_source_arbiter.sv
// Purpose: directed checks of forwarding, dropping, switching, timeout abort, back-pressure and reset.
// Latency: expects queue writes one cycle after the accepting edge.
// Backpressure: drives queue_full directly and observes src0_full/src1_full.
module tb_queue_source_arbiter;
  import queue_source_arbiter_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        src_sel;
  logic        wr_clk;
  logic        active_src;
  logic [15:0] frame_count;
  logic [15:0] drop_count;
  logic        proto_err;

  int n_cmp = 0;
  int n_err = 0;

  queue_source_arbiter_if s0_if ();
  queue_source_arbiter_if s1_if ();
  queue_source_arbiter_if q_if ();

  queue_source_arbiter #(
    .DEFAULT_SRC    (1'b0),
    .TIMEOUT_CYCLES (8),
    .CNT_WIDTH      (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .src_sel      (src_sel),
    .src0         (s0_if),
    .src1         (s1_if),
    .queue        (q_if),
    .queue_wr_clk (wr_clk),
    .active_src   (active_src),
    .frame_count  (frame_count),
    .drop_count   (drop_count),
    .proto_err    (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive both sources, then sample 1 time unit after the next rising edge.
  task automatic step(input token_t d0, input logic e0, input token_t d1, input logic e1);
    s0_if.data  = d0;
    s0_if.wr_en = e0;
    s1_if.data  = d1;
    s1_if.wr_en = e1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_q(input string tag, input logic exp_wr, input token_t exp_data);
    chk({tag, "_wr"}, {31'd0, q_if.wr_en}, {31'd0, exp_wr});
    if (exp_wr) chk({tag, "_data"}, {15'd0, q_if.data}, {15'd0, exp_data});
  endtask

  token_t t1 [4];
  token_t t2 [5];

  initial begin
    t1 = '{TOKEN_SOF, TOKEN_ROW, 17'h00ABC, TOKEN_EOF};
    t2 = '{TOKEN_SOF, TOKEN_ROW, 17'h00011, 17'h00022, TOKEN_EOF};

    reset_n     = 1'b0;
    src_sel     = 1'b0;
    s0_if.data  = '0;
    s0_if.wr_en = 1'b0;
    s1_if.data  = '0;
    s1_if.wr_en = 1'b0;
    q_if.full   = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    chk("rst_wr", {31'd0, q_if.wr_en}, 32'd0);
    chk("rst_data", {15'd0, q_if.data}, 32'd0);
    chk("rst_active", {31'd0, active_src}, 32'd0);
    chk("rst_frames", {16'd0, frame_count}, 32'd0);
    chk("rst_drops", {16'd0, drop_count}, 32'd0);
    chk("rst_proto", {31'd0, proto_err}, 32'd0);
    chk("wr_clk", {31'd0, wr_clk}, {31'd0, clk});
    reset_n = 1'b1;

    // 1: back-to-back src0 frame passes through with one cycle latency
    for (int i = 0; i < 4; i++) begin
      step(t1[i], 1'b1, '0, 1'b0);
      chk_q("t1_tok", 1'b1, t1[i]);
    end
    step('0, 1'b0, '0, 1'b0);
    chk_q("t1_idle", 1'b0, '0);
    chk("t1_frames", {16'd0, frame_count}, 32'd1);
    chk("t1_drops", {16'd0, drop_count}, 32'd0);

    // 2: src1 frame while src0 owns the queue (queue full, src1 still free-running)
    q_if.full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step('0, 1'b0, t2[i], 1'b1);
      chk_q("t2_nowr", 1'b0, '0);
      chk("t2_s1full", {31'd0, s1_if.full}, 32'd0);
    end
    chk("t2_s0full", {31'd0, s0_if.full}, 32'd1);
    chk("t2_drops", {16'd0, drop_count}, 32'd5);
    q_if.full = 1'b0;

    // 3: switch request mid src0 frame completes only after EOF
    step(TOKEN_SOF, 1'b1, '0, 1'b0);
    chk_q("t3_sof0", 1'b1, TOKEN_SOF);
    step(TOKEN_ROW, 1'b1, '0, 1'b0);
    src_sel = 1'b1;
    step(17'h00123, 1'b1, 17'h00055, 1'b1);
    chk_q("t3_pix", 1'b1, 17'h00123);
    chk("t3_act_mid", {31'd0, active_src}, 32'd0);
    step(TOKEN_EOF, 1'b1, 17'h00055, 1'b1);
    chk_q("t3_eof", 1'b1, TOKEN_EOF);
    chk("t3_act_eof", {31'd0, active_src}, 32'd0);
    chk("t3_frames", {16'd0, frame_count}, 32'd2);
    step('0, 1'b0, 17'h00055, 1'b1);
    chk("t3_act_sw", {31'd0, active_src}, 32'd1);
    chk_q("t3_gap", 1'b0, '0);
    step('0, 1'b0, 17'h00055, 1'b1);
    chk_q("t3_seekdrop", 1'b0, '0);
    step('0, 1'b0, TOKEN_SOF, 1'b1);
    chk_q("t3_sof1", 1'b1, TOKEN_SOF);
    chk("t3_drops", {16'd0, drop_count}, 32'd9);
    step('0, 1'b0, TOKEN_ROW, 1'b1);
    step('0, 1'b0, TOKEN_EOF, 1'b1);
    chk("t3_frames1", {16'd0, frame_count}, 32'd3);

    // 4: stalled src0 frame aborted after 8 cycles of pending switch
    src_sel = 1'b0;
    step('0, 1'b0, '0, 1'b0);
    step(TOKEN_SOF, 1'b1, '0, 1'b0);
    step(TOKEN_ROW, 1'b1, '0, 1'b0);
    step(17'h00001, 1'b1, '0, 1'b0);
    chk("t4_act0", {31'd0, active_src}, 32'd0);
    src_sel = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step('0, 1'b0, '0, 1'b0);
      chk_q("t4_wait", 1'b0, '0);
    end
    chk("t4_act_wait", {31'd0, active_src}, 32'd0);
    step('0, 1'b0, '0, 1'b0);
    chk_q("t4_inj", 1'b1, TOKEN_EOF);
    chk("t4_frames", {16'd0, frame_count}, 32'd4);
    chk("t4_act1", {31'd0, active_src}, 32'd1);
    step(17'h00077, 1'b1, 17'h00066, 1'b1);
    chk_q("t4_ign", 1'b0, '0);
    step(17'h00077, 1'b1, TOKEN_SOF, 1'b1);
    chk_q("t4_sof1", 1'b1, TOKEN_SOF);
    chk("t4_drops", {16'd0, drop_count}, 32'd12);
    step('0, 1'b0, TOKEN_ROW, 1'b1);
    step('0, 1'b0, TOKEN_EOF, 1'b1);
    chk("t4_frames1", {16'd0, frame_count}, 32'd5);

    // 5: queue_full held 20 cycles during src0 frame
    src_sel = 1'b0;
    step('0, 1'b0, '0, 1'b0);
    step(TOKEN_SOF, 1'b1, '0, 1'b0);
    chk_q("t5_sof", 1'b1, TOKEN_SOF);
    step(TOKEN_ROW, 1'b1, '0, 1'b0);
    q_if.full = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(17'h00AAA, 1'b1, '0, 1'b0);
      chk_q("t5_stall", 1'b0, '0);
      chk("t5_s0full", {31'd0, s0_if.full}, 32'd1);
      chk("t5_s1full", {31'd0, s1_if.full}, 32'd0);
    end
    q_if.full = 1'b0;
    step(17'h00AAA, 1'b1, '0, 1'b0);
    chk_q("t5_pix", 1'b1, 17'h00AAA);
    step(TOKEN_EOF, 1'b1, '0, 1'b0);
    chk_q("t5_eof", 1'b1, TOKEN_EOF);
    step('0, 1'b0, '0, 1'b0);
    chk_q("t5_idle", 1'b0, '0);
    chk("t5_frames", {16'd0, frame_count}, 32'd6);
    chk("t5_drops", {16'd0, drop_count}, 32'd12);

    // 6: protocol errors, then asynchronous reset mid-frame
    step(TOKEN_SOF, 1'b1, '0, 1'b0);
    step(TOKEN_ROW, 1'b1, '0, 1'b0);
    chk("t6_proto0", {31'd0, proto_err}, 32'd0);
    step(TOKEN_SOF, 1'b1, '0, 1'b0);
    chk_q("t6_sof_fwd", 1'b1, TOKEN_SOF);
    chk("t6_proto1", {31'd0, proto_err}, 32'd1);
    step(TOKEN_EOF, 1'b1, '0, 1'b0);
    step(TOKEN_ROW, 1'b1, '0, 1'b0);
    chk_q("t6_gaprow", 1'b0, '0);
    chk("t6_proto2", {31'd0, proto_err}, 32'd1);
    chk("t6_drops", {16'd0, drop_count}, 32'd13);
    chk("t6_frames", {16'd0, frame_count}, 32'd7);
    step(TOKEN_SOF, 1'b1, '0, 1'b0);
    step(TOKEN_ROW, 1'b1, '0, 1'b0);
    step(17'h00321, 1'b1, '0, 1'b0);
    chk_q("t6_pix", 1'b1, 17'h00321);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_wr", {31'd0, q_if.wr_en}, 32'd0);
    chk("t6_rst_data", {15'd0, q_if.data}, 32'd0);
    chk("t6_rst_frames", {16'd0, frame_count}, 32'd0);
    chk("t6_rst_drops", {16'd0, drop_count}, 32'd0);
    chk("t6_rst_proto", {31'd0, proto_err}, 32'd0);
    chk("t6_rst_active", {31'd0, active_src}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(TOKEN_ROW, 1'b1, '0, 1'b0);
    chk_q("t6_seek_row", 1'b0, '0);
    chk("t6_seek_drop", {16'd0, drop_count}, 32'd1);
    step(TOKEN_SOF, 1'b1, '0, 1'b0);
    chk_q("t6_seek_sof", 1'b1, TOKEN_SOF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
